// File: rtl/ysyx_22041211_div_unit_pkg.sv
// ysyx_22041211_div_unit_pkg
// Shared definitions for the RV32M divide/remainder unit: the datapath width,
// the operation encodings, the FSM state encodings and small operand helpers.
// Optional feature macro used by the unit: YSYX_22041211_DIV_EARLY_OUT_EN.
package ysyx_22041211_div_unit_pkg;

   localparam int DATA_LEN = 32;

   // Bit 1 selects remainder, bit 0 selects unsigned.
   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } div_state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return !op[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

   // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [DATA_LEN-1:0] abs_val(input logic [DATA_LEN-1:0] v);
      return v[DATA_LEN-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/ysyx_22041211_div_unit_if.sv
// ysyx_22041211_div_unit_if
// Request/response bundle between the EX stage and the divide unit.
//   master (EX side): drives in_valid_i, div_op_i, src1, src2, flush_i,
//                     out_ready_i; observes in_ready_o, out_valid_o, result.
//   slave  (unit)   : the mirror image.
interface ysyx_22041211_div_unit_if;
   import ysyx_22041211_div_unit_pkg::*;

   logic                in_valid_i;
   logic                in_ready_o;
   logic [1:0]          div_op_i;
   logic [DATA_LEN-1:0] src1;
   logic [DATA_LEN-1:0] src2;
   logic                flush_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [DATA_LEN-1:0] result;

   modport master (
      output in_valid_i, div_op_i, src1, src2, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, result
   );

   modport slave (
      input  in_valid_i, div_op_i, src1, src2, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, result
   );

endinterface

// File: rtl/ysyx_22041211_div_step.sv
// ysyx_22041211_div_step
// One combinational radix-2 restoring step.
//   rem          : running remainder (always < divisor)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor magnitude
//   rem_next     : remainder after this step
//   q_bit        : quotient bit produced by this step
module ysyx_22041211_div_step
   import ysyx_22041211_div_unit_pkg::*;
(
   input  logic [DATA_LEN-1:0] rem,
   input  logic                dividend_bit,
   input  logic [DATA_LEN-1:0] divisor,
   output logic [DATA_LEN-1:0] rem_next,
   output logic                q_bit
);

   logic [DATA_LEN:0] partial;
   logic [DATA_LEN:0] diff;

   assign partial = {rem, dividend_bit};
   // Because rem < divisor, partial < 2*divisor, so the 33-bit difference
   // always lies within +/-2^32 and its top bit is exactly the borrow out.
   assign diff     = partial - {1'b0, divisor};
   assign q_bit    = ~diff[DATA_LEN];
   assign rem_next = q_bit ? diff[DATA_LEN-1:0] : partial[DATA_LEN-1:0];

endmodule

// File: rtl/ysyx_22041211_div_unit.sv
// ysyx_22041211_div_unit
// Multi-cycle DIV/DIVU/REM/REMU unit: radix-2 restoring division on operand
// magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ysyx_22041211_div_unit_if.slave (operand request, result response,
//           pipeline flush)
// Optional feature: define YSYX_22041211_DIV_EARLY_OUT_EN to finish in one
// cycle when |dividend| < |divisor| (quotient 0, remainder = dividend).
module ysyx_22041211_div_unit
   import ysyx_22041211_div_unit_pkg::*;
(
   input logic                     clk,
   input logic                     rst_n,
   ysyx_22041211_div_unit_if.slave bus
);

   div_state_e          state_reg, state_next;
   logic [4:0]          cnt_reg;
   logic [1:0]          op_reg;
   logic                neg_q_reg, neg_r_reg;
   // The dividend register shifts left each step; quotient bits enter at the
   // bottom, so after 32 steps it holds the unsigned quotient.
   logic [DATA_LEN-1:0] dividend_reg, divisor_reg, rem_reg, result_reg;

   logic                accept, is_signed, div_zero, ovf, early, special;
   logic [DATA_LEN-1:0] mag1, mag2, special_result;
   logic [DATA_LEN-1:0] step_rem;
   logic                step_q;

   assign bus.in_ready_o  = (state_reg == ST_IDLE);
   assign bus.out_valid_o = (state_reg == ST_DONE);
   assign bus.result      = result_reg;

   assign accept    = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
   assign is_signed = op_is_signed(bus.div_op_i);
   assign mag1      = is_signed ? abs_val(bus.src1) : bus.src1;
   assign mag2      = is_signed ? abs_val(bus.src2) : bus.src2;
   assign div_zero  = (bus.src2 == '0);
   assign ovf       = is_signed && (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
`ifdef YSYX_22041211_DIV_EARLY_OUT_EN
   assign early     = (mag1 < mag2) && !div_zero;
`else
   assign early     = 1'b0;
`endif
   assign special   = div_zero || ovf || early;

   always_comb begin
      special_result = '0;
      if (div_zero) begin
         special_result = op_is_rem(bus.div_op_i) ? bus.src1 : 32'hFFFF_FFFF;
      end else if (ovf) begin
         special_result = op_is_rem(bus.div_op_i) ? 32'h0 : 32'h8000_0000;
      end else begin
         special_result = op_is_rem(bus.div_op_i) ? bus.src1 : 32'h0;
      end
   end

   ysyx_22041211_div_step u_step (
      .rem          (rem_reg),
      .dividend_bit (dividend_reg[DATA_LEN-1]),
      .divisor      (divisor_reg),
      .rem_next     (step_rem),
      .q_bit        (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
         ST_CALC: if (cnt_reg == 5'd31) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: if (bus.out_ready_i) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (bus.flush_i) state_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         op_reg       <= '0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         rem_reg      <= '0;
         result_reg   <= '0;
      end else if (bus.flush_i) begin
         cnt_reg      <= '0;
         rem_reg      <= '0;
         result_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: if (accept) begin
               op_reg       <= bus.div_op_i;
               neg_q_reg    <= is_signed && (bus.src1[DATA_LEN-1] ^ bus.src2[DATA_LEN-1]);
               neg_r_reg    <= is_signed && bus.src1[DATA_LEN-1];
               dividend_reg <= mag1;
               divisor_reg  <= mag2;
               rem_reg      <= '0;
               cnt_reg      <= '0;
               if (special) result_reg <= special_result;
            end
            ST_CALC: begin
               dividend_reg <= {dividend_reg[DATA_LEN-2:0], step_q};
               rem_reg      <= step_rem;
               cnt_reg      <= cnt_reg + 5'd1;  // wraps back to 0 after 31
            end
            ST_FIX: begin
               if (op_is_rem(op_reg))
                  result_reg <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
               else
                  result_reg <= neg_q_reg ? (~dividend_reg + 1'b1) : dividend_reg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_div_unit.sv
// tb_ysyx_22041211_div_unit
// Scoreboard bench: the driver pushes the hand-computed result and expected
// latency of each request; a monitor pops and compares on every result
// handshake. Latency is the index of the clock edge that first registers
// out_valid_o high, counting the accept edge as edge 0.
module tb_ysyx_22041211_div_unit;
   import ysyx_22041211_div_unit_pkg::*;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] res;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_22041211_div_unit_if dif();

   ysyx_22041211_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic prev_valid = 1'b0;

`ifdef YSYX_22041211_DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 0;
`else
   localparam int EARLY_LAT = 33;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: runs shortly after the falling edge, once the driver has settled.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (dif.out_valid_o && !prev_valid) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid: got out_valid_o=1 result=%h, required no output", dif.result);
            end else if (cyc - acc_cyc != sb[0].lat) begin
               bad++;
               $display("FAIL latency: got %0d, required %0d", cyc - acc_cyc, sb[0].lat);
            end
         end
         if (dif.out_valid_o && dif.out_ready_i && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (dif.result !== e.res) begin
               bad++;
               $display("FAIL result op=%0d: got %h, required %h", e.op, dif.result, e.res);
            end else begin
               $display("txn op=%0d result=%h expected=%h", e.op, dif.result, e.res);
            end
         end
      end
      prev_valid = dif.out_valid_o;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   // Present one request at a falling edge and hold it until the accept edge.
   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int i;
      @(negedge clk);
      for (i = 0; i < 100 && !dif.in_ready_o; i++) @(negedge clk);
      if (!dif.in_ready_o) check("ready_timeout", 32'(dif.in_ready_o), 32'd1);
      dif.div_op_i   = op;
      dif.src1       = a;
      dif.src2       = b;
      dif.in_valid_i = 1'b1;
      acc_cyc        = cyc + 1;
      @(negedge clk);
      dif.in_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 100 && !(dif.in_ready_o && sb.size() == 0); i++) @(negedge clk);
      if (!(dif.in_ready_o && sb.size() == 0)) begin
         check("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   // bp=1 holds out_ready_i low for 5 cycles once the result is presented.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input bit bp);
      int i;
      if (bp) dif.out_ready_i = 1'b0;
      sb.push_back('{op: op, res: res, lat: lat});
      start(op, a, b);
      if (bp) begin
         for (i = 0; i < 100 && !dif.out_valid_o; i++) @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            check("bp_result", dif.result, res);
            check("bp_valid", 32'(dif.out_valid_o), 32'd1);
            check("bp_ready", 32'(dif.in_ready_o), 32'd0);
            @(negedge clk);
         end
         dif.out_ready_i = 1'b1;
      end
      wait_drain();
   endtask

   initial begin
      dif.in_valid_i  = 1'b0;
      dif.div_op_i    = 2'b00;
      dif.src1        = '0;
      dif.src2        = '0;
      dif.flush_i     = 1'b0;
      dif.out_ready_i = 1'b1;

      #12;
      check("rst_in_ready", 32'(dif.in_ready_o), 32'd1);
      check("rst_out_valid", 32'(dif.out_valid_o), 32'd0);
      check("rst_result", dif.result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(DIV_OP_DIV,  32'd100,        32'd7,          32'h0000_000E, 33, 1'b0);
      issue(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, 1'b0);
      issue(DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF, 33, 1'b0);
      issue(DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF, 0,  1'b0);
      issue(DIV_OP_REM,  32'h8000_0000,  32'd0,          32'h8000_0000, 0,  1'b0);
      issue(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 0,  1'b0);
      issue(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 0,  1'b0);
      issue(DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 33, 1'b0);
      issue(DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 33, 1'b0);
      issue(DIV_OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 33, 1'b0);
      issue(DIV_OP_REMU, 32'd100,        32'd7,          32'h0000_0002, 33, 1'b0);
      issue(DIV_OP_DIVU, 32'd3,          32'd10,         32'h0000_0000, EARLY_LAT, 1'b0);
      issue(DIV_OP_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD, EARLY_LAT, 1'b0);

      // Backpressure in DONE.
      issue(DIV_OP_DIV,  32'd100,        32'd7,          32'h0000_000E, 33, 1'b1);

      // Flush while the counter reads 10; nothing may come out.
      start(DIV_OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      dif.flush_i = 1'b1;
      @(negedge clk);
      dif.flush_i = 1'b0;
      check("flush_in_ready", 32'(dif.in_ready_o), 32'd1);
      check("flush_out_valid", 32'(dif.out_valid_o), 32'd0);
      repeat (40) @(negedge clk);
      issue(DIV_OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, 33, 1'b0);

      // Asynchronous reset in the middle of CALC.
      start(DIV_OP_DIV, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(dif.in_ready_o), 32'd1);
      check("arst_out_valid", 32'(dif.out_valid_o), 32'd0);
      check("arst_result", dif.result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(DIV_OP_DIV, 32'hFFFF_FFF7, 32'd2, 32'hFFFF_FFFC, 33, 1'b0);
      issue(DIV_OP_DIVU, 32'd3, 32'd10, 32'h0000_0000, EARLY_LAT, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
